// File: rtl/irq_sched.sv
// Interrupt request scheduler: synchronizes and edge-detects NSRC sources, holds them
// pending under a software mask, and hands the highest-priority one to the core via IRQ.
module irq_sched #(
    parameter int unsigned NSRC = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic            kernel,
    input  logic            mask_wr,
    input  logic [NSRC-1:0] mask_din,
    input  logic            irq_ack,
    input  logic            irq_done,
    output logic            IRQ,
    output logic [2:0]      irq_id,
    output logic [NSRC-1:0] mask_q,
    output logic [NSRC-1:0] pending_q
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        SERVICE = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [NSRC-1:0] s1_q, s2_q, s3_q, s3_d;
    logic [NSRC-1:0] rise, clr, cand;
    logic [NSRC-1:0] pending_d, mask_d;
    logic [1:0]      warm_q, warm_d;
    logic [2:0]      id_q, id_d, sel_id;
    logic            sel_vld;

    // Until the pipeline has been loaded twice after reset, s3 follows s1 alongside s2,
    // so lines already high at reset release never look like a rising edge.
    always_comb begin
        warm_d = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
        s3_d   = warm_q[1] ? s2_q : s1_q;
        rise   = s2_q & ~s3_q;
    end

    always_comb begin
        clr = '0;
        if (state_q == REQ && irq_ack) begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                clr[i] = (id_q == 3'(i));
            end
        end
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = mask_wr ? mask_din : mask_q;
    end

    always_comb begin
        cand    = pending_q & mask_q;
        sel_vld = 1'b0;
        sel_id  = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (cand[i] && !sel_vld) begin
                sel_vld = 1'b1;
                sel_id  = 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (sel_vld && !kernel) begin
                    state_d = REQ;
                    id_d    = sel_id;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (irq_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            warm_q    <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            s1_q      <= irq_src;
            s2_q      <= s1_q;
            s3_q      <= s3_d;
            warm_q    <= warm_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            id_q      <= id_d;
        end
    end

    assign IRQ    = (state_q == REQ);
    assign irq_id = id_q;

endmodule

// File: tb/tb_irq_sched.sv
// Self-checking bench for irq_sched: per-cycle vector table with a scoreboard queue,
// plus hand-written reset sequences.
module tb_irq_sched;

    typedef struct {
        logic [3:0] src;
        logic       kern;
        logic       mwr;
        logic [3:0] mdin;
        logic       ack;
        logic       done;
        logic       e_irq;
        logic [2:0] e_id;
        logic [3:0] e_pend;
        logic [3:0] e_mask;
    } vec_t;

    typedef struct {
        logic       irq;
        logic [2:0] id;
        logic [3:0] pend;
        logic [3:0] mask;
        int         tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_src;
    logic       kernel;
    logic       mask_wr;
    logic [3:0] mask_din;
    logic       irq_ack;
    logic       irq_done;
    logic       IRQ;
    logic [2:0] irq_id;
    logic [3:0] mask_q;
    logic [3:0] pending_q;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sbq[$];
    vec_t tbl[52];

    irq_sched #(.NSRC(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .irq_src  (irq_src),
        .kernel   (kernel),
        .mask_wr  (mask_wr),
        .mask_din (mask_din),
        .irq_ack  (irq_ack),
        .irq_done (irq_done),
        .IRQ      (IRQ),
        .irq_id   (irq_id),
        .mask_q   (mask_q),
        .pending_q(pending_q)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] src, input logic kern, input logic mwr,
                                input logic [3:0] mdin, input logic ack, input logic done,
                                input logic e_irq, input logic [2:0] e_id,
                                input logic [3:0] e_pend, input logic [3:0] e_mask);
        vec_t v;
        v.src = src; v.kern = kern; v.mwr = mwr; v.mdin = mdin; v.ack = ack; v.done = done;
        v.e_irq = e_irq; v.e_id = e_id; v.e_pend = e_pend; v.e_mask = e_mask;
        return v;
    endfunction

    task automatic check(input string nm, input int tag, input logic [7:0] act,
                         input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", nm, tag, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int tag);
        exp_t e;
        irq_src  = v.src;
        kernel   = v.kern;
        mask_wr  = v.mwr;
        mask_din = v.mdin;
        irq_ack  = v.ack;
        irq_done = v.done;
        sbq.push_back('{v.e_irq, v.e_id, v.e_pend, v.e_mask, tag});
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            check("scoreboard_empty", tag, 8'd1, 8'd0);
        end else begin
            e = sbq.pop_front();
            check("IRQ",       e.tag, {7'd0, IRQ},     {7'd0, e.irq});
            check("irq_id",    e.tag, {5'd0, irq_id},  {5'd0, e.id});
            check("pending_q", e.tag, {4'd0, pending_q}, {4'd0, e.pend});
            check("mask_q",    e.tag, {4'd0, mask_q},  {4'd0, e.mask});
        end
    endtask

    task automatic check_all_zero(input string nm, input int tag);
        check({nm, "_IRQ"},  tag, {7'd0, IRQ},       8'd0);
        check({nm, "_id"},   tag, {5'd0, irq_id},    8'd0);
        check({nm, "_pend"}, tag, {4'd0, pending_q}, 8'd0);
        check({nm, "_mask"}, tag, {4'd0, mask_q},    8'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation ran past its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        // src, kern, mwr, mdin, ack, done | IRQ, id, pending, mask
        tbl[0]  = mk(4'h0, 0, 1, 4'hF, 0, 0,  0, 0, 4'h0, 4'hF);
        tbl[1]  = mk(4'h0, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 4'hF);
        tbl[2]  = mk(4'h0, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 4'hF);
        tbl[3]  = mk(4'h0, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 4'hF);
        // basic flow on source 2
        tbl[4]  = mk(4'h4, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 4'hF);
        tbl[5]  = mk(4'h4, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 4'hF);
        tbl[6]  = mk(4'h0, 0, 0, 4'h0, 0, 0,  0, 0, 4'h4, 4'hF);
        tbl[7]  = mk(4'h0, 0, 0, 4'h0, 0, 0,  1, 2, 4'h4, 4'hF);
        tbl[8]  = mk(4'h0, 0, 0, 4'h0, 0, 0,  1, 2, 4'h4, 4'hF);
        tbl[9]  = mk(4'h0, 0, 0, 4'h0, 0, 0,  1, 2, 4'h4, 4'hF);
        tbl[10] = mk(4'h0, 0, 0, 4'h0, 1, 0,  0, 2, 4'h0, 4'hF);
        tbl[11] = mk(4'h0, 0, 0, 4'h0, 1, 0,  0, 2, 4'h0, 4'hF);
        tbl[12] = mk(4'h0, 0, 0, 4'h0, 0, 1,  0, 2, 4'h0, 4'hF);
        tbl[13] = mk(4'h0, 0, 0, 4'h0, 0, 0,  0, 2, 4'h0, 4'hF);
        // priority and masking: sources 1 and 3 with source 1 masked
        tbl[14] = mk(4'h0, 0, 1, 4'hD, 0, 0,  0, 2, 4'h0, 4'hD);
        tbl[15] = mk(4'hA, 0, 0, 4'h0, 0, 0,  0, 2, 4'h0, 4'hD);
        tbl[16] = mk(4'hA, 0, 0, 4'h0, 0, 0,  0, 2, 4'h0, 4'hD);
        tbl[17] = mk(4'hA, 0, 0, 4'h0, 0, 0,  0, 2, 4'hA, 4'hD);
        tbl[18] = mk(4'hA, 0, 0, 4'h0, 0, 0,  1, 3, 4'hA, 4'hD);
        tbl[19] = mk(4'hA, 0, 0, 4'h0, 1, 0,  0, 3, 4'h2, 4'hD);
        tbl[20] = mk(4'h0, 0, 0, 4'h0, 0, 1,  0, 3, 4'h2, 4'hD);
        tbl[21] = mk(4'h0, 0, 1, 4'hF, 0, 0,  0, 3, 4'h2, 4'hF);
        tbl[22] = mk(4'h0, 0, 0, 4'h0, 0, 0,  1, 1, 4'h2, 4'hF);
        tbl[23] = mk(4'h0, 0, 0, 4'h0, 1, 0,  0, 1, 4'h0, 4'hF);
        tbl[24] = mk(4'h0, 0, 0, 4'h0, 0, 1,  0, 1, 4'h0, 4'hF);
        // kernel inhibit, then commitment against kernel rise and mask clear
        tbl[25] = mk(4'h1, 1, 0, 4'h0, 0, 0,  0, 1, 4'h0, 4'hF);
        tbl[26] = mk(4'h1, 1, 0, 4'h0, 0, 0,  0, 1, 4'h0, 4'hF);
        tbl[27] = mk(4'h0, 1, 0, 4'h0, 0, 0,  0, 1, 4'h1, 4'hF);
        tbl[28] = mk(4'h0, 1, 0, 4'h0, 0, 0,  0, 1, 4'h1, 4'hF);
        tbl[29] = mk(4'h0, 1, 0, 4'h0, 0, 0,  0, 1, 4'h1, 4'hF);
        tbl[30] = mk(4'h0, 0, 0, 4'h0, 0, 0,  1, 0, 4'h1, 4'hF);
        tbl[31] = mk(4'h0, 1, 0, 4'h0, 0, 0,  1, 0, 4'h1, 4'hF);
        tbl[32] = mk(4'h0, 1, 1, 4'h0, 0, 0,  1, 0, 4'h1, 4'h0);
        tbl[33] = mk(4'h0, 1, 0, 4'h0, 1, 0,  0, 0, 4'h0, 4'h0);
        tbl[34] = mk(4'h0, 0, 1, 4'hF, 0, 1,  0, 0, 4'h0, 4'hF);
        // same-cycle set and clear on source 0
        tbl[35] = mk(4'h1, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 4'hF);
        tbl[36] = mk(4'h1, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 4'hF);
        tbl[37] = mk(4'h0, 0, 0, 4'h0, 0, 0,  0, 0, 4'h1, 4'hF);
        tbl[38] = mk(4'h0, 0, 0, 4'h0, 0, 0,  1, 0, 4'h1, 4'hF);
        tbl[39] = mk(4'h0, 0, 0, 4'h0, 0, 0,  1, 0, 4'h1, 4'hF);
        tbl[40] = mk(4'h1, 0, 0, 4'h0, 0, 0,  1, 0, 4'h1, 4'hF);
        tbl[41] = mk(4'h1, 0, 0, 4'h0, 0, 0,  1, 0, 4'h1, 4'hF);
        tbl[42] = mk(4'h0, 0, 0, 4'h0, 1, 0,  0, 0, 4'h1, 4'hF);
        tbl[43] = mk(4'h0, 0, 0, 4'h0, 0, 1,  0, 0, 4'h1, 4'hF);
        tbl[44] = mk(4'h0, 0, 0, 4'h0, 0, 0,  1, 0, 4'h1, 4'hF);
        tbl[45] = mk(4'h0, 0, 0, 4'h0, 1, 0,  0, 0, 4'h0, 4'hF);
        tbl[46] = mk(4'h0, 0, 0, 4'h0, 0, 1,  0, 0, 4'h0, 4'hF);
        // into SERVICE on source 0 with sources 1 and 2 still pending
        tbl[47] = mk(4'h7, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 4'hF);
        tbl[48] = mk(4'h7, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 4'hF);
        tbl[49] = mk(4'h0, 0, 0, 4'h0, 0, 0,  0, 0, 4'h7, 4'hF);
        tbl[50] = mk(4'h0, 0, 0, 4'h0, 0, 0,  1, 0, 4'h7, 4'hF);
        tbl[51] = mk(4'h0, 0, 0, 4'h0, 1, 0,  0, 0, 4'h6, 4'hF);

        // reset held with all sources high
        reset    = 1'b0;
        irq_src  = 4'hF;
        kernel   = 1'b0;
        mask_wr  = 1'b0;
        mask_din = 4'h0;
        irq_ack  = 1'b0;
        irq_done = 1'b0;
        #2;
        check_all_zero("rst_async", 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst_held", 0);
        reset = 1'b1;

        // lines high at release must not become pending
        for (int i = 0; i < 10; i++) begin
            step(mk(4'hF, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 4'h0), 200 + i);
        end

        for (int i = 0; i < 52; i++) begin
            step(tbl[i], i);
        end

        // asynchronous reset while in SERVICE with sources 1 and 2 pending
        #3;
        reset = 1'b0;
        #1;
        check_all_zero("rst_service", 300);
        @(negedge clk);
        reset = 1'b1;
        step(mk(4'h0, 0, 0, 4'h0, 0, 1,  0, 0, 4'h0, 4'h0), 301);
        step(mk(4'h0, 0, 1, 4'hF, 0, 0,  0, 0, 4'h0, 4'hF), 302);
        step(mk(4'h4, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 4'hF), 303);
        step(mk(4'h4, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 4'hF), 304);
        step(mk(4'h0, 0, 0, 4'h0, 0, 0,  0, 0, 4'h4, 4'hF), 305);
        step(mk(4'h0, 0, 0, 4'h0, 0, 0,  1, 2, 4'h4, 4'hF), 306);

        // asynchronous reset drops an outstanding request immediately
        #3;
        reset = 1'b0;
        #1;
        check_all_zero("rst_req", 307);
        @(negedge clk);
        reset = 1'b1;
        step(mk(4'h0, 0, 0, 4'h0, 1, 0,  0, 0, 4'h0, 4'h0), 308);
        step(mk(4'h0, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 4'h0), 309);

        check("scoreboard_drained", 999, 8'(sbq.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
